// File: rtl/pcm_pkg.sv
// Shared types and constants for the multi-channel PCM stream player.
package pcm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DONE  = 2'd2
    } pcm_state_t;

    localparam int VOL_SHIFT = 6;

    // Roughly 2 dB steps; index 15 (64) is unity gain once shifted by VOL_SHIFT.
    localparam logic [6:0] VOL_LOG [16] = '{
        7'd0,  7'd1,  7'd2,  7'd3,  7'd4,  7'd5,  7'd6,  7'd8,
        7'd11, 7'd14, 7'd18, 7'd23, 7'd30, 7'd38, 7'd49, 7'd64
    };

    function automatic logic [15:0] vol_scale(input logic [15:0] smp, input logic [3:0] idx);
        logic signed [21:0] a;
        logic signed [21:0] b;
        logic signed [21:0] p;
        a = {{6{smp[15]}}, smp};
        b = {15'b0, VOL_LOG[idx]};
        p = a * b;
        return p[VOL_SHIFT+15:VOL_SHIFT];
    endfunction

endpackage

// File: rtl/pcm_stream_mc_if.sv
// CPU-side sample FIFO port of the PCM stream player.
import pcm_pkg::*;

// A byte is accepted on a rising clk edge where fifo_write (valid) is high and
// fifo_full is low (ready); fifo_write while full drops the byte.
interface pcm_stream_mc_if #(parameter int FIFO_AW = 12);
    logic [7:0]       fifo_wrdata;
    logic             fifo_write;
    logic             fifo_reset;
    logic             fifo_full;
    logic             fifo_almost_empty;
    logic [FIFO_AW:0] fifo_level;

    modport master (
        output fifo_wrdata, fifo_write, fifo_reset,
        input  fifo_full, fifo_almost_empty, fifo_level
    );

    modport slave (
        input  fifo_wrdata, fifo_write, fifo_reset,
        output fifo_full, fifo_almost_empty, fifo_level
    );
endinterface

// File: rtl/pcm_fifo.sv
// Synchronous byte FIFO with registered read data, level tracking and a
// synchronous flush.
import pcm_pkg::*;

module pcm_fifo #(
    parameter int FIFO_AW   = 12,
    parameter int AE_THRESH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    input  logic             rd_en,
    output logic [7:0]       rd_data,
    output logic [FIFO_AW:0] level,
    output logic             full,
    output logic             empty,
    output logic             almost_empty
);

    localparam int DEPTH = 2 ** FIFO_AW;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wptr;
    logic [FIFO_AW-1:0] rptr;
    logic               wr_ok;
    logic               rd_ok;

    assign full         = (level == (FIFO_AW+1)'(DEPTH));
    assign empty        = (level == '0);
    assign almost_empty = (level < (FIFO_AW+1)'(AE_THRESH));
    assign wr_ok        = wr_en && !full && !flush;
    assign rd_ok        = rd_en && !empty && !flush;

    // Storage carries no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            level   <= '0;
            rd_data <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_ok) begin
                rptr    <= rptr + 1'b1;
                rd_data <= mem[rptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/pcm_stream_mc.sv
// Multi-channel PCM player: FIFO-fed frame fetcher paced by a fractional rate
// accumulator, with per-channel log volume on the outputs.
import pcm_pkg::*;

module pcm_stream_mc #(
    parameter int NUM_CH    = 2,
    parameter int FIFO_AW   = 12,
    parameter int RATE_W    = 16,
    parameter int AE_THRESH = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  next_sample,
    input  logic [RATE_W-1:0]     sample_rate,
    input  logic [2:0]            num_ch_m1,
    input  logic                  mode_16bit,
    input  logic                  fmt_unsigned,
    input  logic                  hold_on_empty,
    input  logic [4*NUM_CH-1:0]   volume,
    input  logic                  underrun_clr,
    pcm_stream_mc_if.slave        bus,
    output logic                  underrun,
    output logic [16*NUM_CH-1:0]  audio_out,
    output pcm_state_t            dbg_state
);

    localparam int                MAX_BYTES = 2 * NUM_CH;
    localparam logic [RATE_W-1:0] FULL_RATE = {1'b1, {(RATE_W-1){1'b0}}};
    localparam logic [3:0]        NCH_MAX   = 4'(NUM_CH);
    localparam logic [2:0]        NCH_TOP   = 3'(NUM_CH - 1);

    pcm_state_t        state, state_nxt;
    logic [RATE_W-1:0] acc;
    logic [RATE_W-1:0] rate_inc;
    logic [RATE_W-1:0] acc_sum;
    logic              new_sample;

    logic [2:0]        nch_in;
    logic [2:0]        nch_lat;
    logic              m16_lat;
    logic              uns_lat;
    logic [3:0]        bytes_m1;
    logic [3:0]        cnt;
    logic [7:0]        frame_bytes [MAX_BYTES];
    logic [15:0]       smp         [NUM_CH];
    logic [15:0]       out_reg     [NUM_CH];

    logic              rd_en;
    logic [7:0]        rd_data;
    logic              fifo_empty;
    logic              start;
    logic              load;
    logic              zero_out;
    logic              set_ur;

    pcm_fifo #(
        .FIFO_AW   (FIFO_AW),
        .AE_THRESH (AE_THRESH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .flush        (bus.fifo_reset),
        .wr_en        (bus.fifo_write),
        .wr_data      (bus.fifo_wrdata),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .level        (bus.fifo_level),
        .full         (bus.fifo_full),
        .empty        (fifo_empty),
        .almost_empty (bus.fifo_almost_empty)
    );

    // A frame is due whenever the accumulator MSB flips.
    assign rate_inc = (sample_rate > FULL_RATE) ? FULL_RATE : sample_rate;
    assign acc_sum  = acc + rate_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            new_sample <= 1'b0;
        end else begin
            new_sample <= 1'b0;
            if (next_sample) begin
                acc        <= acc_sum;
                new_sample <= acc_sum[RATE_W-1] ^ acc[RATE_W-1];
            end
        end
    end

    assign nch_in    = ({1'b0, num_ch_m1} >= NCH_MAX) ? NCH_TOP : num_ch_m1;
    assign bytes_m1  = m16_lat ? {nch_lat, 1'b1} : {1'b0, nch_lat};
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        start     = 1'b0;
        load      = 1'b0;
        zero_out  = 1'b0;
        set_ur    = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_empty) begin
                    zero_out = !hold_on_empty;
                    set_ur   = new_sample;
                end else if (new_sample) begin
                    rd_en     = 1'b1;
                    start     = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (cnt < bytes_m1) begin
                    // Running dry mid-frame drops the partial frame.
                    if (fifo_empty) begin
                        set_ur    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        rd_en = 1'b1;
                    end
                end else begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                load      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (bus.fifo_reset) begin
            state_nxt = IDLE;
            rd_en     = 1'b0;
            start     = 1'b0;
            load      = 1'b0;
            zero_out  = 1'b0;
            set_ur    = 1'b0;
        end
    end

    // Per-channel sample assembly; channels beyond the active count mirror channel 0.
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            smp[k] = '0;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (m16_lat) begin
                smp[k] = {frame_bytes[2*k+1], frame_bytes[2*k]};
            end else begin
                smp[k] = {frame_bytes[k] ^ {uns_lat, 7'b0}, 8'h00};
            end
        end
        for (int k = 1; k < NUM_CH; k++) begin
            if (3'(k) > nch_lat) begin
                smp[k] = smp[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            nch_lat  <= '0;
            m16_lat  <= 1'b0;
            uns_lat  <= 1'b0;
            underrun <= 1'b0;
            for (int i = 0; i < MAX_BYTES; i++) begin
                frame_bytes[i] <= '0;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                out_reg[k] <= '0;
            end
        end else begin
            if (start) begin
                cnt     <= '0;
                nch_lat <= nch_in;
                m16_lat <= mode_16bit;
                uns_lat <= fmt_unsigned;
            end else if (state == FETCH) begin
                cnt <= cnt + 1'b1;
                for (int i = 0; i < MAX_BYTES; i++) begin
                    if (cnt == 4'(i)) begin
                        frame_bytes[i] <= rd_data;
                    end
                end
            end

            if (set_ur) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end

            if (load) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    out_reg[k] <= smp[k];
                end
            end else if (zero_out) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    out_reg[k] <= '0;
                end
            end
        end
    end

    // Volume stage runs every cycle so gain changes land one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            audio_out <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                audio_out[16*k +: 16] <= vol_scale(out_reg[k], volume[4*k +: 4]);
            end
        end
    end

endmodule

// File: tb/tb_pcm_stream_mc.sv
// Directed self-checking bench for pcm_stream_mc (NUM_CH=2, FIFO_AW=12).
import pcm_pkg::*;

module tb_pcm_stream_mc;

    logic        clk;
    logic        rst;
    logic        next_sample;
    logic [15:0] sample_rate;
    logic [2:0]  num_ch_m1;
    logic        mode_16bit;
    logic        fmt_unsigned;
    logic        hold_on_empty;
    logic [7:0]  volume;
    logic        underrun_clr;
    logic        underrun;
    logic [31:0] audio_out;
    pcm_state_t  dut_state;
    logic [7:0]  fill_val;

    int checks   = 0;
    int failures = 0;

    pcm_stream_mc_if #(.FIFO_AW(12)) bus ();

    pcm_stream_mc #(
        .NUM_CH    (2),
        .FIFO_AW   (12),
        .RATE_W    (16),
        .AE_THRESH (1024)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .next_sample   (next_sample),
        .sample_rate   (sample_rate),
        .num_ch_m1     (num_ch_m1),
        .mode_16bit    (mode_16bit),
        .fmt_unsigned  (fmt_unsigned),
        .hold_on_empty (hold_on_empty),
        .volume        (volume),
        .underrun_clr  (underrun_clr),
        .bus           (bus),
        .underrun      (underrun),
        .audio_out     (audio_out),
        .dbg_state     (dut_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "simulation time limit reached");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        bus.fifo_write  = 1'b1;
        bus.fifo_wrdata = b;
        @(negedge clk);
        bus.fifo_write  = 1'b0;
    endtask

    task automatic write_burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.fifo_write  = 1'b1;
            bus.fifo_wrdata = fill_val;
            fill_val        = fill_val + 8'd1;
        end
        @(negedge clk);
        bus.fifo_write = 1'b0;
    endtask

    task automatic strobe();
        @(negedge clk);
        next_sample = 1'b1;
        @(negedge clk);
        next_sample = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst             = 1'b1;
        next_sample     = 1'b0;
        sample_rate     = 16'h8000;
        num_ch_m1       = 3'd1;
        mode_16bit      = 1'b1;
        fmt_unsigned    = 1'b0;
        hold_on_empty   = 1'b0;
        volume          = 8'hFF;
        underrun_clr    = 1'b0;
        bus.fifo_wrdata = 8'h00;
        bus.fifo_write  = 1'b0;
        bus.fifo_reset  = 1'b0;
        fill_val        = 8'h01;

        idle(3);
        check("rst_audio", audio_out, 32'h0);
        check("rst_level", 32'(bus.fifo_level), 32'd0);
        check("rst_full", 32'(bus.fifo_full), 32'd0);
        check("rst_ae", 32'(bus.fifo_almost_empty), 32'd1);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_state", 32'(dut_state), 32'(IDLE));
        rst = 1'b0;
        idle(2);

        // Stereo 16-bit at full rate, exact output latency
        hold_on_empty = 1'b1;
        write_byte(8'h34);
        write_byte(8'h12);
        write_byte(8'h78);
        write_byte(8'h56);
        check("st16_level_in", 32'(bus.fifo_level), 32'd4);
        strobe();
        idle(6);
        check("st16_not_yet", audio_out, 32'h0);
        idle(1);
        check("st16_audio", audio_out, 32'h56781234);
        check("st16_level_out", 32'(bus.fifo_level), 32'd0);
        idle(5);
        check("st16_held", audio_out, 32'h56781234);

        // Mono 8-bit offset-binary
        num_ch_m1    = 3'd0;
        mode_16bit   = 1'b0;
        fmt_unsigned = 1'b1;
        write_byte(8'h80);
        strobe();
        idle(6);
        check("mono_u80", audio_out, 32'h00000000);
        write_byte(8'hFF);
        strobe();
        idle(6);
        check("mono_uff", audio_out, 32'h7F007F00);

        // Channel count above NUM_CH clamps to stereo
        num_ch_m1    = 3'd7;
        mode_16bit   = 1'b1;
        fmt_unsigned = 1'b0;
        write_byte(8'h01);
        write_byte(8'h00);
        write_byte(8'h02);
        write_byte(8'h00);
        strobe();
        idle(9);
        check("nch_clamp", audio_out, 32'h00020001);
        check("nch_clamp_level", 32'(bus.fifo_level), 32'd0);

        // Volume: ch0=0x4000, ch1=0xC000
        num_ch_m1 = 3'd1;
        write_byte(8'h00);
        write_byte(8'h40);
        write_byte(8'h00);
        write_byte(8'hC0);
        strobe();
        idle(9);
        check("vol_unity", audio_out, 32'hC0004000);
        volume = 8'hE8;
        idle(1);
        check("vol_8_14", audio_out, 32'hCF000B00);
        volume = 8'h08;
        idle(1);
        check("vol_ch1_mute", audio_out, 32'h00000B00);
        volume = 8'hFF;
        idle(1);
        check("vol_restore", audio_out, 32'hC0004000);

        // Underrun mid-frame: 3 of 4 bytes queued
        write_byte(8'hAA);
        write_byte(8'hBB);
        write_byte(8'hCC);
        check("ur_level_in", 32'(bus.fifo_level), 32'd3);
        strobe();
        idle(8);
        check("ur_level_out", 32'(bus.fifo_level), 32'd0);
        check("ur_flag", 32'(underrun), 32'd1);
        check("ur_audio_kept", audio_out, 32'hC0004000);
        check("ur_state", 32'(dut_state), 32'(IDLE));
        underrun_clr = 1'b1;
        idle(1);
        underrun_clr = 1'b0;
        idle(1);
        check("ur_cleared", 32'(underrun), 32'd0);

        // Strobe on an empty FIFO sets underrun even with clear held
        underrun_clr = 1'b1;
        strobe();
        idle(1);
        check("ur_set_prio", 32'(underrun), 32'd1);
        underrun_clr = 1'b0;
        idle(1);
        check("ur_sticky", 32'(underrun), 32'd1);
        underrun_clr = 1'b1;
        idle(1);
        underrun_clr = 1'b0;
        check("ur_clr2", 32'(underrun), 32'd0);

        // Empty FIFO with hold_on_empty=0 zeroes outputs
        hold_on_empty = 1'b0;
        idle(2);
        check("empty_zero", audio_out, 32'h0);
        hold_on_empty = 1'b1;

        // Half rate: frames on every 2nd strobe
        sample_rate = 16'h4000;
        num_ch_m1   = 3'd0;
        mode_16bit  = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            write_byte(8'(i));
        end
        check("rate_level_in", 32'(bus.fifo_level), 32'd10);
        for (int i = 1; i <= 8; i++) begin
            strobe();
            idle(6);
            check($sformatf("rate_level_s%0d", i), 32'(bus.fifo_level), 32'(10 - i / 2));
        end
        check("rate_audio", audio_out, 32'h04000400);

        // Oversized rate clamps to full rate
        sample_rate = 16'hFFFF;
        strobe();
        idle(6);
        check("rate_clamp_level", 32'(bus.fifo_level), 32'd5);
        check("rate_clamp_audio", audio_out, 32'h05000500);

        // Flush
        @(negedge clk);
        bus.fifo_reset = 1'b1;
        @(negedge clk);
        bus.fifo_reset = 1'b0;
        check("flush_level", 32'(bus.fifo_level), 32'd0);
        check("flush_audio", audio_out, 32'h05000500);
        check("flush_ae", 32'(bus.fifo_almost_empty), 32'd1);

        // Almost-empty boundary and full
        sample_rate = 16'h8000;
        write_burst(1023);
        check("ae_1023_level", 32'(bus.fifo_level), 32'd1023);
        check("ae_1023", 32'(bus.fifo_almost_empty), 32'd1);
        write_burst(1);
        check("ae_1024", 32'(bus.fifo_almost_empty), 32'd0);
        write_burst(3072);
        check("full_level", 32'(bus.fifo_level), 32'd4096);
        check("full_flag", 32'(bus.fifo_full), 32'd1);
        write_byte(8'hEE);
        check("full_drop_level", 32'(bus.fifo_level), 32'd4096);
        strobe();
        idle(6);
        check("full_first_byte", audio_out, 32'h01000100);
        check("full_after_read", 32'(bus.fifo_level), 32'd4095);
        check("full_clear", 32'(bus.fifo_full), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
